// File: rtl/vga_tmds_encoder.sv
// DVI 1.0 TMDS encoder for the OSD pixel stream: the input register feeds a
// transition-minimising stage, then a DC-balance stage with a disparity counter per channel.
module vga_tmds_encoder #(
  parameter bit         c_sync_invert  = 1'b0,
  parameter logic [9:0] c_clock_symbol = 10'b1111100000
) (
  input  logic       clk_pixel,
  input  logic       resetn,
  input  logic       clk_pixel_ena,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_blank,
  output logic [9:0] out_red,
  output logic [9:0] out_green,
  output logic [9:0] out_blue,
  output logic [9:0] out_clock
);

  localparam int unsigned NCH = 3;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic signed [4:0] cnt;
    logic [9:0]        sym;
  } balance_t;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Sums are formed at 6 bits so the +/-2 term and N1-N0 cannot wrap before truncation.
  function automatic balance_t balance(input logic [8:0] q, input logic signed [4:0] cnt);
    balance_t          r;
    logic [3:0]        n1;
    logic [3:0]        n0;
    logic signed [5:0] cnt_w;
    logic signed [5:0] diff;
    logic signed [5:0] sum;
    n1    = ones8(q[7:0]);
    n0    = 4'd8 - n1;
    cnt_w = {cnt[4], cnt};
    diff  = $signed({2'b00, n1}) - $signed({2'b00, n0});
    if ((cnt == 5'sd0) || (n1 == n0)) begin
      r.sym = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
      sum   = q[8] ? (cnt_w + diff) : (cnt_w - diff);
    end else if ((!cnt[4] && (n1 > n0)) || (cnt[4] && (n0 > n1))) begin
      r.sym = {1'b1, q[8], ~q[7:0]};
      sum   = cnt_w + (q[8] ? 6'sd2 : 6'sd0) - diff;
    end else begin
      r.sym = {1'b0, q[8], q[7:0]};
      sum   = cnt_w - (q[8] ? 6'sd0 : 6'sd2) + diff;
    end
    r.cnt = sum[4:0];
    return r;
  endfunction

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  logic [7:0] pix [NCH];
  logic [9:0] sym [NCH];
  logic       blank0;
  logic       blank1;
  logic [1:0] sync0;
  logic [1:0] sync1;

  assign pix[0] = i_b;
  assign pix[1] = i_g;
  assign pix[2] = i_r;

  // Control flags travel alongside the data so blank and sync stay aligned with the symbols.
  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      blank0 <= 1'b1;
      blank1 <= 1'b1;
      sync0  <= '0;
      sync1  <= '0;
    end else if (clk_pixel_ena) begin
      blank0 <= i_blank;
      sync0  <= {i_vsync, i_hsync} ^ {2{c_sync_invert}};
      blank1 <= blank0;
      sync1  <= sync0;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    logic [7:0]        din;
    logic [8:0]        qm;
    logic [9:0]        sym_r;
    logic signed [4:0] cnt;
    logic [1:0]        ctl;
    balance_t          bal;

    if (ch == 0) begin : g_sync
      assign ctl = sync1;
    end else begin : g_nosync
      assign ctl = 2'b00;
    end

    assign bal = balance(qm, cnt);

    always_ff @(posedge clk_pixel) begin
      if (!resetn) begin
        din   <= '0;
        qm    <= '0;
        sym_r <= CTRL_00;
        cnt   <= '0;
      end else if (clk_pixel_ena) begin
        din <= pix[ch];
        qm  <= minimise(din);
        if (blank1) begin
          sym_r <= ctrl_symbol(ctl);
          cnt   <= '0;
        end else begin
          sym_r <= bal.sym;
          cnt   <= bal.cnt;
        end
      end
    end

    assign sym[ch] = sym_r;
  end

  assign out_blue  = sym[0];
  assign out_green = sym[1];
  assign out_red   = sym[2];
  assign out_clock = c_clock_symbol;

endmodule

// File: tb/tb_vga_tmds_encoder.sv
// Bench for vga_tmds_encoder: disparity-based reference encoder with a token pipeline,
// directed literal scenarios, and a long randomized stream.
module tb_vga_tmds_encoder;

  logic       clk_pixel = 1'b0;
  logic       resetn;
  logic       clk_pixel_ena;
  logic [7:0] i_r;
  logic [7:0] i_g;
  logic [7:0] i_b;
  logic       i_hsync;
  logic       i_vsync;
  logic       i_blank;
  logic [9:0] out_red;
  logic [9:0] out_green;
  logic [9:0] out_blue;
  logic [9:0] out_clock;

  int checks = 0;
  int errors = 0;

  vga_tmds_encoder #(
    .c_sync_invert (1'b0),
    .c_clock_symbol(10'b1111100000)
  ) dut (
    .clk_pixel    (clk_pixel),
    .resetn       (resetn),
    .clk_pixel_ena(clk_pixel_ena),
    .i_r          (i_r),
    .i_g          (i_g),
    .i_b          (i_b),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .i_blank      (i_blank),
    .out_red      (out_red),
    .out_green    (out_green),
    .out_blue     (out_blue),
    .out_clock    (out_clock)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Reference model state: channel 0 = blue, 1 = green, 2 = red.
  logic [7:0] m_px0 [3];
  logic [7:0] m_px1 [3];
  bit         m_bl0;
  bit         m_bl1;
  logic [1:0] m_c0;
  logic [1:0] m_c1;
  int         m_cnt [3];
  logic [9:0] m_sym [3];
  bit         m_data = 1'b0;
  int         m_seq = 0;
  bit         cmp_en = 1'b0;
  logic [9:0] dut_sym [3];

  assign dut_sym[0] = out_blue;
  assign dut_sym[1] = out_green;
  assign dut_sym[2] = out_red;

  logic [9:0] seq00  [4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
  logic [7:0] ff_px  [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
  bit         ff_bl  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [9:0] ff_exp [3] = '{10'h200, 10'h354, 10'h200};
  bit         en_ena [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  bit         en_bl  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] en_px  [8] = '{8'h00, 8'hFF, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [9:0] en_exp [8] = '{10'h354, 10'h354, 10'h354, 10'h354, 10'h100, 10'h100, 10'h354, 10'h354};

  task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // Chooses inversion from the sign of running vs. word disparity; the new running
  // disparity is simply the old one plus the ones-minus-zeros of the emitted symbol.
  function automatic void ref_encode(input logic [7:0] d, input int cin,
                                     output logic [9:0] sym, output int cout);
    logic [8:0] q;
    int         n;
    int         disp;
    bit         xn;
    bit         inv;
    n    = $countones(d);
    xn   = (n > 4) || (n == 4 && d[0] == 1'b0);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    disp = 2 * $countones(q[7:0]) - 8;
    if (cin == 0 || disp == 0) inv = !q[8];
    else inv = ((cin > 0) == (disp > 0));
    sym  = {inv, q[8], (inv ? ~q[7:0] : q[7:0])};
    cout = cin + 2 * $countones(sym) - 10;
  endfunction

  task automatic model_update();
    logic [7:0] px_in [3];
    px_in[0] = i_b;
    px_in[1] = i_g;
    px_in[2] = i_r;
    if (!resetn) begin
      m_bl0 = 1'b1;
      m_bl1 = 1'b1;
      m_c0  = 2'b00;
      m_c1  = 2'b00;
      for (int ch = 0; ch < 3; ch++) begin
        m_cnt[ch] = 0;
        m_sym[ch] = 10'h354;
      end
      m_data = 1'b0;
      m_seq++;
    end else if (clk_pixel_ena) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (m_bl1) begin
          m_sym[ch] = ctl_sym(ch == 0 ? m_c1 : 2'b00);
          m_cnt[ch] = 0;
        end else begin
          ref_encode(m_px1[ch], m_cnt[ch], m_sym[ch], m_cnt[ch]);
        end
      end
      m_data = !m_bl1;
      m_seq++;
      m_px1 = m_px0;
      m_bl1 = m_bl0;
      m_c1  = m_c0;
      m_px0 = px_in;
      m_bl0 = i_blank;
      m_c0  = {i_vsync, i_hsync};
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    model_update();
    #1;
  endtask

  task automatic drive(input bit bl, input bit hs, input bit vs, input logic [7:0] px);
    i_blank = bl;
    i_hsync = hs;
    i_vsync = vs;
    i_r     = px;
    i_g     = px;
    i_b     = px;
  endtask

  task automatic check_all(input string name, input logic [9:0] exp);
    check10({name, "_blue"}, out_blue, exp);
    check10({name, "_green"}, out_green, exp);
    check10({name, "_red"}, out_red, exp);
  endtask

  // Every-cycle comparison against the model plus a running-disparity bound per active run.
  initial begin
    int rd [3];
    int last_seq;
    last_seq = 0;
    for (int ch = 0; ch < 3; ch++) rd[ch] = 0;
    forever begin
      @(negedge clk_pixel);
      if (cmp_en) begin
        check10("model_blue", out_blue, m_sym[0]);
        check10("model_green", out_green, m_sym[1]);
        check10("model_red", out_red, m_sym[2]);
        check10("clock_symbol", out_clock, 10'h3E0);
        if (m_seq != last_seq) begin
          last_seq = m_seq;
          for (int ch = 0; ch < 3; ch++) begin
            if (m_data) begin
              rd[ch] += 2 * $countones(dut_sym[ch]) - 10;
              checks++;
              if (rd[ch] > 12 || rd[ch] < -12) begin
                errors++;
                $display("FAIL disparity_bound ch%0d: got %0d want within +/-12", ch, rd[ch]);
              end
            end else begin
              rd[ch] = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [9:0] s;
    int         c;
    bit         bl;
    int         mode;

    ref_encode(8'h00, 0, s, c);
    check10("ref_00_from_0", s, 10'h100);
    check_int("ref_00_from_0_cnt", c, -8);
    ref_encode(8'h00, -8, s, c);
    check10("ref_00_from_m8", s, 10'h3FF);
    check_int("ref_00_from_m8_cnt", c, 2);
    ref_encode(8'h00, 2, s, c);
    check10("ref_00_from_2", s, 10'h100);
    check_int("ref_00_from_2_cnt", c, -6);
    ref_encode(8'hFF, 0, s, c);
    check10("ref_ff_from_0", s, 10'h200);
    check_int("ref_ff_from_0_cnt", c, -8);

    resetn        = 1'b0;
    clk_pixel_ena = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    cmp_en = 1'b1;
    check_all("reset", 10'h354);
    check10("reset_clock", out_clock, 10'h3E0);

    resetn = 1'b1;
    repeat (3) step();
    check_all("ctl00", 10'h354);
    check10("ctl00_clock", out_clock, 10'h3E0);

    drive(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (3) step();
    check10("ctl_hs_blue", out_blue, 10'h0AB);
    check10("ctl_hs_green", out_green, 10'h354);
    check10("ctl_hs_red", out_red, 10'h354);

    drive(1'b1, 1'b1, 1'b1, 8'h00);
    repeat (3) step();
    check10("ctl_vshs_blue", out_blue, 10'h2AB);

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k >= 2) check_all("zeros_seq", seq00[k-2]);
    end

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      drive(ff_bl[k], 1'b0, 1'b0, ff_px[k]);
      step();
      if (k >= 2) check_all("ff_blank_ff", ff_exp[k-2]);
    end

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) step();
    for (int k = 0; k < 8; k++) begin
      clk_pixel_ena = en_ena[k];
      drive(en_bl[k], 1'b0, 1'b0, en_px[k]);
      step();
      check_all("ena_toggle", en_exp[k]);
    end
    clk_pixel_ena = 1'b1;

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (4) step();
    check_all("pre_reset", 10'h3FF);
    resetn = 1'b0;
    step();
    check_all("midline_reset", 10'h354);
    resetn = 1'b1;
    step();
    check_all("post_reset_1", 10'h354);
    step();
    check_all("post_reset_2", 10'h354);
    step();
    check_all("post_reset_data", 10'h100);
    step();
    check_all("post_reset_data2", 10'h3FF);

    bl = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 39) == 0) bl = !bl;
      resetn        = ($urandom_range(0, 2999) != 0);
      clk_pixel_ena = ($urandom_range(0, 7) != 0);
      i_blank       = bl;
      i_hsync       = 1'($urandom_range(0, 1));
      i_vsync       = 1'($urandom_range(0, 1));
      mode          = int'($urandom_range(0, 3));
      if (mode == 0) begin
        i_r = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        i_g = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        i_b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      end else begin
        i_r = 8'($urandom);
        i_g = 8'($urandom);
        i_b = 8'($urandom);
      end
      step();
    end

    resetn        = 1'b1;
    clk_pixel_ena = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (4) step();
    @(negedge clk_pixel);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_tmds_encoder.md
# vga_tmds_encoder

Downstream stage of the OSD overlay pipeline. Consumes the pixel-rate VGA stream (`o_r`/`o_g`/`o_b`, `o_hsync`/`o_vsync`/`o_blank`) that the OSD overlay emits and produces four 10-bit TMDS symbols per pixel: one each for blue, green and red, plus a clock-channel symbol. Each data channel has its own DC-balancing disparity counter, as defined by DVI 1.0. The symbols feed the serializer/DDR output stage.

## Interface
Parameters:
- `c_sync_invert`, default 0: 1 inverts hsync and vsync before they are encoded.
- `c_clock_symbol`, default 10'b1111100000: constant emitted on `out_clock`.

Ports:
- `clk_pixel`  in  1  pixel clock.
- `resetn`  in  1  reset. One clock; reset is synchronous and active-low.
- `clk_pixel_ena`  in  1  pipeline advance enable. When low, all state holds.
- `i_r`, `i_g`, `i_b`  in  8 each  pixel colour.
- `i_hsync`, `i_vsync`  in  1 each  sync signals.
- `i_blank`  in  1  1 = control period, 0 = active video.
- `out_red`, `out_green`, `out_blue`  out  10 each  TMDS symbols. Bit 0 is transmitted first.
- `out_clock`  out  10  clock-channel symbol.

## Operation
- Three identical channel encoders. Blue carries {c1,c0} = {vsync,hsync}. Green and red carry {c1,c0} = 00.
- Stage 1 (transition minimisation), on the registered input byte D:
  - N1(D) = number of ones in D.
  - If N1(D) > 4, or N1(D) == 4 and D[0] == 0: XNOR chain, q_m[8] = 0.
  - Otherwise: XOR chain, q_m[8] = 1.
  - q_m[0] = D[0].
  - The blank flag and c1/c0 are carried alongside.
- Stage 2 (DC balance). N1/N0 here are counted over q_m[7:0]. cnt is a signed 5-bit value per channel.
  - If cnt == 0 or N1 == N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (N1−N0) : (N0−N1).
  - Else if (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2·q_m[8] + (N0−N1).
  - Else: out = {0, q_m[8], q_m[7:0]}. cnt += −2·(~q_m[8]) + (N1−N0).
- Control period (blank = 1):
  - Output is selected by {c1,c0}: 00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011 (MSB first).
  - cnt is forced to 0.
- Arithmetic width rules:
  - cnt stays within −8..+8 by construction.
  - Intermediate sums are computed at 6 bits signed, then truncated to 5 bits.
  - The ±2 term is sign-extended before the add.
- `out_clock` is `c_clock_symbol` at all times, including during reset.

## Timing
- Latency: 2 enabled cycles from input to symbol. Input sampled at edge N appears on the outputs after edge N+2.
- Throughput: one symbol per enabled cycle. There is no handshake and no backpressure.
- `clk_pixel_ena` = 0:
  - Pipeline registers, cnt and outputs hold their values.
  - Inputs presented in that cycle are ignored.
- Reset (`resetn` = 0 at a clock edge):
  - All cnt = 0.
  - Pipeline flags are set to blank = 1, c = 00.
  - `out_red`/`out_green`/`out_blue` = 10'b1101010100.
  - Reset is applied regardless of `clk_pixel_ena`.
  - Reset asserted mid-line discards symbols in flight. The first post-reset data symbol encodes from cnt = 0.
- Transitions of blank:
  - blank 1→0: the first active pixel encodes from cnt = 0.
  - blank 0→1: the control symbol appears exactly 2 cycles later, and cnt is 0 for the next active pixel.

## Test plan
- Reset, then blank = 1, hsync = 0, vsync = 0 → all three data channels = 0x354, `out_clock` = 0x3E0. With hsync = 1: blue = 0x0AB, green/red = 0x354. With vsync = 1, hsync = 1: blue = 0x2AB.
- Active stream, data 0x00 on all channels from cnt = 0 → symbols 0x100, 0x3FF, 0x100, 0x3FF…; cnt sequence −8, 2, −6, 4…
- Active, single pixel 0xFF from cnt = 0 → 0x200, cnt = −8. Then blank for 1 pixel → control symbol, cnt = 0. Then 0xFF again → 0x200.
- Latency and enable: pulse blank low for one enabled cycle with B = 0x00, with `clk_pixel_ena` toggling 1,0,1,0 → the data symbol appears only after 2 enabled edges, and outputs hold during ena = 0.
- Random 10,000-pixel frames compared against a reference DVI 1.0 encoder model → bit-exact match. Running disparity (count of ones minus zeros over all emitted data symbols) stays bounded within ±12 at every symbol.
- Assert `resetn` = 0 for 1 cycle mid-active-line with cnt ≠ 0 → next outputs = 0x354, and the next data pixel 0x00 encodes as 0x100 (cnt restarted at 0).
